// File: rtl/result_byte_serializer_pkg.sv
// Shared FSM type, sizing constants and byte-selection helpers for the
// result byte serializer.
package result_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SCALAR_BYTES = 4;

  function automatic int bytes_per_elem(input int iwidth);
    return (iwidth + 7) / 8;
  endfunction

  // Byte idx of a 32-bit scalar, MSB first.
  function automatic logic [7:0] scalar_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/result_byte_serializer_elem_byte_mux.sv
// Combinational selector: element elem_idx of the vector, zero-extended to
// whole bytes, and its byte byte_idx counted from the MSB end.
module elem_byte_mux
  import result_tx_pkg::*;
#(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 1024,
  localparam int EW     = (NINPUTS > 1) ? $clog2(NINPUTS) : 1
) (
  input  logic [IWIDTH-1:0] vec_data [NINPUTS],
  input  logic [EW-1:0]     elem_idx,
  input  logic [1:0]        byte_idx,
  output logic [7:0]        byte_o
);

  localparam int BPE = bytes_per_elem(IWIDTH);

  logic [IWIDTH-1:0]  elem_s;
  logic [8*BPE-1:0]   ext_s;

  always_comb begin
    elem_s = '0;
    ext_s  = '0;
    byte_o = 8'h00;
    if (int'(elem_idx) < NINPUTS) begin
      elem_s = vec_data[elem_idx];
    end else begin
      elem_s = '0;
    end
    ext_s[IWIDTH-1:0] = elem_s;
    if (int'(byte_idx) < BPE) begin
      byte_o = ext_s[8*(BPE-1-int'(byte_idx)) +: 8];
    end else begin
      byte_o = 8'h00;
    end
  end

endmodule

// File: rtl/result_byte_serializer.sv
// Serializes a scalar (4 bytes) or vector result (element 0 first, MSB first)
// into a registered valid/ready byte stream.
module result_byte_serializer
  import result_tx_pkg::*;
#(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 1024,
  localparam int EW     = (NINPUTS > 1) ? $clog2(NINPUTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_scalar,
  input  logic [IWIDTH-1:0] vec_data [NINPUTS],
  input  logic [31:0]       scalar_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int BPE = bytes_per_elem(IWIDTH);

  state_e       state_q, state_d;
  logic         scalar_mode_q, scalar_mode_d;
  logic [31:0]  scalar_q, scalar_d;
  logic [EW-1:0] elem_idx_q, elem_idx_d;
  logic [1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]   tx_data_q, tx_data_d;

  logic         last_s, byte_wrap_s;
  logic [EW-1:0] nxt_elem_s, mux_elem_s;
  logic [1:0]   nxt_byte_s, mux_byte_s;
  logic [7:0]   mux_data_s;

  // The mux always looks one byte ahead so tx_data can be registered.
  elem_byte_mux #(.IWIDTH(IWIDTH), .NINPUTS(NINPUTS)) u_mux (
    .vec_data (vec_data),
    .elem_idx (mux_elem_s),
    .byte_idx (mux_byte_s),
    .byte_o   (mux_data_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      scalar_mode_q <= 1'b0;
      scalar_q      <= 32'h0000_0000;
      elem_idx_q    <= '0;
      byte_idx_q    <= 2'd0;
      tx_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      scalar_mode_q <= scalar_mode_d;
      scalar_q      <= scalar_d;
      elem_idx_q    <= elem_idx_d;
      byte_idx_q    <= byte_idx_d;
      tx_data_q     <= tx_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    scalar_mode_d = scalar_mode_q;
    scalar_d      = scalar_q;
    elem_idx_d    = elem_idx_q;
    byte_idx_d    = byte_idx_q;
    tx_data_d     = tx_data_q;

    if (scalar_mode_q) begin
      last_s      = (byte_idx_q == 2'(SCALAR_BYTES - 1));
      byte_wrap_s = 1'b0;
    end else begin
      last_s      = (elem_idx_q == EW'(NINPUTS - 1)) && (byte_idx_q == 2'(BPE - 1));
      byte_wrap_s = (byte_idx_q == 2'(BPE - 1));
    end
    nxt_elem_s = byte_wrap_s ? (elem_idx_q + EW'(1)) : elem_idx_q;
    nxt_byte_s = byte_wrap_s ? 2'd0 : (byte_idx_q + 2'd1);

    if (state_q == SEND) begin
      mux_elem_s = nxt_elem_s;
      mux_byte_s = nxt_byte_s;
    end else begin
      mux_elem_s = '0;
      mux_byte_s = 2'd0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = SEND;
          scalar_mode_d = is_scalar;
          scalar_d      = scalar_data;
          elem_idx_d    = '0;
          byte_idx_d    = 2'd0;
          tx_data_d     = is_scalar ? scalar_byte(scalar_data, 2'd0) : mux_data_s;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (last_s) begin
            state_d    = DONE;
            elem_idx_d = '0;
            byte_idx_d = 2'd0;
            tx_data_d  = 8'h00;
          end else begin
            elem_idx_d = nxt_elem_s;
            byte_idx_d = nxt_byte_s;
            tx_data_d  = scalar_mode_q ? scalar_byte(scalar_q, nxt_byte_s) : mux_data_s;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        elem_idx_d = '0;
        byte_idx_d = 2'd0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q == SEND);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_result_byte_serializer.sv
// Directed checks of the result byte serializer on a 4-element instance plus a
// randomized-backpressure stream on a 1024-element instance.
module tb_result_byte_serializer;

  localparam int IW = 10;
  localparam int NS = 4;
  localparam int NL = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_start = 1'b0, s_is_scalar = 1'b0, s_tx_ready = 1'b0;
  logic [IW-1:0] s_vec [NS];
  logic [31:0]   s_scalar = 32'h0;
  logic [7:0]    s_tx_data;
  logic          s_tx_valid, s_busy, s_done;

  logic          l_start = 1'b0, l_is_scalar = 1'b0, l_tx_ready = 1'b0;
  logic [IW-1:0] l_vec [NL];
  logic [31:0]   l_scalar = 32'h0;
  logic [7:0]    l_tx_data;
  logic          l_tx_valid, l_busy, l_done;

  result_byte_serializer #(.IWIDTH(IW), .NINPUTS(NS)) dut_s (
    .clk(clk), .reset(rst_n), .start(s_start), .is_scalar(s_is_scalar),
    .vec_data(s_vec), .scalar_data(s_scalar), .tx_data(s_tx_data),
    .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .busy(s_busy), .done(s_done)
  );

  result_byte_serializer #(.IWIDTH(IW), .NINPUTS(NL)) dut_l (
    .clk(clk), .reset(rst_n), .start(l_start), .is_scalar(l_is_scalar),
    .vec_data(l_vec), .scalar_data(l_scalar), .tx_data(l_tx_data),
    .tx_valid(l_tx_valid), .tx_ready(l_tx_ready), .busy(l_busy), .done(l_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the small instance; returns at the negedge after acceptance.
  task automatic start_small(input logic scal, input logic [31:0] data);
    s_start = 1'b1; s_is_scalar = scal; s_scalar = data;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  // Expects n bytes (MSB-first packed in bytes) with tx_ready held 1, then one done.
  task automatic stream_check(input string tag, input logic [63:0] bytes, input int n,
                              input bit poke_done);
    s_tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, s_tx_data}, {24'd0, bytes[8*(n-1-i) +: 8]});
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, s_tx_valid}, 32'd1);
      @(negedge clk);
    end
    chk({tag, "_done"}, {29'd0, s_done, s_tx_valid, s_busy}, 32'b100);
    if (poke_done) begin
      s_start = 1'b1; s_is_scalar = 1'b1; s_scalar = 32'hCAFE_F00D;
    end
    @(negedge clk);
    s_start = 1'b0;
    chk({tag, "_after"}, {29'd0, s_done, s_tx_valid, s_busy}, 32'b000);
  endtask

  logic [7:0] exp_q [$];

  initial begin
    s_vec[0] = 10'h3FF; s_vec[1] = 10'h001; s_vec[2] = 10'h200; s_vec[3] = 10'h155;
    for (int i = 0; i < NL; i++) l_vec[i] = IW'((i * 37 + 5) & 32'h3FF);

    // Reset state
    @(negedge clk);
    chk("rst_s", {21'd0, s_tx_data, s_tx_valid, s_busy, s_done}, 32'd0);
    chk("rst_l", {21'd0, l_tx_data, l_tx_valid, l_busy, l_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s", {29'd0, s_tx_valid, s_busy, s_done}, 32'd0);

    // Scalar DEADBEEF
    start_small(1'b1, 32'hDEAD_BEEF);
    chk("scal_busy", {31'd0, s_busy}, 32'd1);
    stream_check("scal", 64'hDEAD_BEEF, 4, 1'b0);

    // Vector on the 4-element instance
    start_small(1'b0, 32'h0);
    stream_check("vec", 64'h03FF_0001_0200_0155, 8, 1'b0);

    // Backpressure on the 2nd byte
    start_small(1'b1, 32'hDEAD_BEEF);
    s_tx_ready = 1'b1;
    chk("bp_b0", {24'd0, s_tx_data}, 32'hDE);
    @(negedge clk);
    s_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {23'd0, s_tx_valid, s_tx_data}, {23'd0, 1'b1, 8'hAD});
    end
    stream_check("bp", 64'hAD_BEEF, 3, 1'b0);

    // Start while busy ignored; start coincident with done ignored
    start_small(1'b1, 32'hDEAD_BEEF);
    s_tx_ready = 1'b1;
    s_start = 1'b1; s_scalar = 32'h1234_5678;
    @(negedge clk);
    s_start = 1'b0;
    stream_check("busy_start", 64'hAD_BEEF, 3, 1'b1);
    @(negedge clk);
    chk("done_start_ign", {30'd0, s_tx_valid, s_busy}, 32'd0);

    // Reset mid-transfer, then a fresh vector transfer
    start_small(1'b0, 32'h0);
    s_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("rst_mid_pre", {24'd0, s_tx_data}, 32'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {30'd0, s_tx_valid, s_busy}, 32'd0);
    @(negedge clk);
    chk("rst_mid_nodone", {31'd0, s_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", {29'd0, s_done, s_tx_valid, s_busy}, 32'd0);
    start_small(1'b0, 32'h0);
    stream_check("vec2", 64'h03FF_0001_0200_0155, 8, 1'b0);

    // Large vector with random ready
    for (int i = 0; i < NL; i++) begin
      exp_q.push_back({6'd0, l_vec[i][9:8]});
      exp_q.push_back(l_vec[i][7:0]);
    end
    begin
      int  idx = 0;
      int  n_done = 0;
      int  tail = 0;
      bit  stall = 1'b0;
      logic [7:0] hold_d = 8'h00;
      l_start = 1'b1;
      @(negedge clk);
      l_start = 1'b0;
      for (int cyc = 0; cyc < 20000 && tail < 4; cyc++) begin
        if (stall) chk("rnd_hold", {23'd0, l_tx_valid, l_tx_data}, {23'd0, 1'b1, hold_d});
        if (l_done) n_done++;
        if (n_done > 0) tail++;
        l_tx_ready = ($urandom_range(0, 2) != 0);
        if (l_tx_valid && l_tx_ready) begin
          if (idx < exp_q.size()) chk($sformatf("rnd_byte%0d", idx), {24'd0, l_tx_data}, {24'd0, exp_q[idx]});
          idx++;
        end
        stall  = l_tx_valid && !l_tx_ready;
        hold_d = l_tx_data;
        @(negedge clk);
      end
      chk("rnd_count", idx, 32'd2048);
      chk("rnd_done", n_done, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
